bs_ctrl: RTL and testbench

Sequencing controller for the binary-search datapath. It accepts a start request and an 8-bit target, then probes a sorted synchronous ROM by driving its read address. It compares each read word against the target, narrows the search window, and reports found/not-found with the matching index. It sits between the top-level switch/key logic and the ROM, owning all search-window arithmetic and handshakes.

---
 rtl/bs_pkg.sv | 29 ++
 rtl/bs_lat_timer.sv | 41 ++++
 rtl/bs_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_bs_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bs_pkg
//  Description : Shared types and constants for the binary-search controller:
//                FSM state encoding, default ROM geometry and the legal range
//                of the ROM read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
package bs_pkg;

    // Default ROM geometry
    localparam int c_ADDR_W_DEFAULT = 5;
    localparam int c_DATA_W_DEFAULT = 8;

    // Legal ROM read latency window (cycles)
    localparam int c_RD_LAT_MIN = 1;
    localparam int c_RD_LAT_MAX = 3;

    // Controller state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SEARCH = 3'd2,
        ST_CMP    = 3'd3,
        ST_DONE   = 3'd4
    } bs_state_t;

endpackage : bs_pkg
`default_nettype wire

// File: rtl/bs_lat_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bs_lat_timer
//  Description : Loadable down-counter that paces ROM read latency. It is
//                loaded with RD_LAT-1 whenever a new probe address is set up,
//                decremented while waiting, and flags expiry at zero.
//  Ports       : clk      - system clock
//                reset    - asynchronous active-low reset
//                load     - load load_val (priority over dec)
//                load_val - reload value
//                dec      - decrement request (saturates at zero)
//                expired  - counter is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module bs_lat_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign expired = (r_cnt == '0);

endmodule : bs_lat_timer
`default_nettype wire

// File: rtl/bs_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bs_ctrl
//  Description : Binary-search sequencing controller. Latches a target on a
//                start request, probes an ascending synchronous ROM at the
//                window midpoint, narrows [lo,hi] after each compare and
//                reports found/loc when the search terminates.
//  Ports       : clk, reset (async active-low)
//                start, target          - request handshake
//                rom_addr, rom_q        - ROM read port (rom_addr = mid)
//                busy, done, found, loc - status and result
//                probes                 - probe counter (optional, see below)
//  Config      : define BS_CTRL_PROBE_CNT_EN to add the 'probes' output port.
//  Revision    : 1.0 - initial release
// ============================================================================
module bs_ctrl
    import bs_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] target,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] loc
`ifdef BS_CTRL_PROBE_CNT_EN
    ,
    output logic [$clog2(ADDR_W+2)-1:0] probes
`endif
);

    // Out-of-range latencies are clamped into the supported window
    localparam int c_RD_LAT_EFF = (RD_LAT < c_RD_LAT_MIN) ? c_RD_LAT_MIN :
                                  (RD_LAT > c_RD_LAT_MAX) ? c_RD_LAT_MAX : RD_LAT;
    localparam logic [1:0]        c_WAIT_INIT = 2'(c_RD_LAT_EFF - 1);
    localparam logic [ADDR_W:0]   c_HI_INIT   = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]   c_ONE       = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_MID_MAX   = {ADDR_W{1'b1}};

    bs_state_t r_state, w_state_nxt;

    // lo/hi carry one extra bit so lo can pass hi without wrapping
    logic [ADDR_W:0]   r_lo, r_hi, w_lo_nxt, w_hi_nxt;
    logic [ADDR_W:0]   w_lo_upd, w_hi_upd;
    logic [DATA_W-1:0] r_tgt, w_tgt_nxt;
    logic              r_found, w_found_nxt;
    logic [ADDR_W-1:0] r_loc, w_loc_nxt;
    logic [ADDR_W-1:0] w_mid;
    logic              w_tmr_load, w_tmr_dec, w_tmr_expired;
    logic              w_probe_clr, w_probe_inc;

    // lo+hi never exceeds 2*(2**ADDR_W-1), so ADDR_W+1 bits hold the sum
    assign w_mid = ADDR_W'((r_lo + r_hi) >> 1);

    bs_lat_timer #(
        .CNT_W (2)
    ) u_lat_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_tmr_load),
        .load_val (c_WAIT_INIT),
        .dec      (w_tmr_dec),
        .expired  (w_tmr_expired)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_lo    <= '0;
            r_hi    <= '0;
            r_tgt   <= '0;
            r_found <= 1'b0;
            r_loc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_tgt   <= w_tgt_nxt;
            r_found <= w_found_nxt;
            r_loc   <= w_loc_nxt;
        end
    end

    // ----------------------------------------------------- next state/data
    always_comb begin
        w_state_nxt = r_state;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_tgt_nxt   = r_tgt;
        w_found_nxt = r_found;
        w_loc_nxt   = r_loc;
        w_lo_upd    = r_lo;
        w_hi_upd    = r_hi;
        w_tmr_load  = 1'b0;
        w_tmr_dec   = 1'b0;
        w_probe_clr = 1'b0;
        w_probe_inc = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SETUP;
                end
            end

            ST_SETUP: begin
                w_tgt_nxt   = target;
                w_lo_nxt    = '0;
                w_hi_nxt    = c_HI_INIT;
                w_found_nxt = 1'b0;
                w_loc_nxt   = '0;
                w_tmr_load  = 1'b1;
                w_probe_clr = 1'b1;
                w_state_nxt = ST_SEARCH;
            end

            ST_SEARCH: begin
                // rom_addr is held stable while the ROM read completes
                if (w_tmr_expired) begin
                    w_state_nxt = ST_CMP;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end

            ST_CMP: begin
                w_probe_inc = 1'b1;
                if (rom_q == r_tgt) begin
                    w_found_nxt = 1'b1;
                    w_loc_nxt   = w_mid;
                    w_state_nxt = ST_DONE;
                end else if (rom_q < r_tgt) begin
                    if (w_mid == c_MID_MAX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_lo_upd = {1'b0, w_mid} + c_ONE;
                        w_lo_nxt = w_lo_upd;
                        // window collapsed: not found
                        if (w_lo_upd > r_hi) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_tmr_load  = 1'b1;
                            w_state_nxt = ST_SEARCH;
                        end
                    end
                end else begin
                    if (w_mid == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_hi_upd = {1'b0, w_mid} - c_ONE;
                        w_hi_nxt = w_hi_upd;
                        if (r_lo > w_hi_upd) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_tmr_load  = 1'b1;
                            w_state_nxt = ST_SEARCH;
                        end
                    end
                end
            end

            ST_DONE: begin
                // no auto-restart: start must drop before a new request
                if (!start) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    assign rom_addr = w_mid;
    assign busy     = (r_state == ST_SETUP) || (r_state == ST_SEARCH) ||
                      (r_state == ST_CMP);
    assign done     = (r_state == ST_DONE);
    assign found    = r_found;
    assign loc      = r_loc;

`ifdef BS_CTRL_PROBE_CNT_EN
    localparam int c_PROBE_W = $clog2(ADDR_W+2);

    logic [c_PROBE_W-1:0] r_probes;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_probes <= '0;
        end else if (w_probe_clr) begin
            r_probes <= '0;
        end else if (w_probe_inc) begin
            r_probes <= r_probes + {{(c_PROBE_W-1){1'b0}}, 1'b1};
        end
    end

    assign probes = r_probes;
`else
    // Without the counter the probe strobes have no consumer
    logic w_probe_unused;
    assign w_probe_unused = w_probe_clr ^ w_probe_inc;
`endif

endmodule : bs_ctrl
`default_nettype wire

// File: tb/tb_bs_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bs_ctrl
//  Description : Directed self-checking bench for bs_ctrl with a behavioural
//                one-cycle-latency ROM holding rom[i] = 2*i+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bs_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] target;
    logic [4:0] rom_addr;
    logic [7:0] rom_q;
    logic       busy, done, found;
    logic [4:0] loc;
`ifdef BS_CTRL_PROBE_CNT_EN
    logic [2:0] probes;
`endif

    int checks = 0;
    int errors = 0;
    int exp_addr [6];

    always #5 clk = ~clk;

    // ROM with RD_LAT = 1
    always @(posedge clk) rom_q <= {2'b00, rom_addr, 1'b1};

    bs_ctrl #(
        .ADDR_W (5),
        .DATA_W (8),
        .RD_LAT (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .target   (target),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .loc      (loc)
`ifdef BS_CTRL_PROBE_CNT_EN
        ,
        .probes   (probes)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue a request and follow it to DONE; start is left high on return.
    task automatic do_search(input string tag, input logic [7:0] t, input logic exp_f,
                             input logic [4:0] exp_loc, input int exp_edge, input int exp_p);
        int         k;
        int         np;
        logic [4:0] got [6];
        for (int j = 0; j < 6; j++) got[j] = '0;
        target = t;
        start  = 1'b1;
        @(posedge clk);              // edge 0: start sampled in IDLE
        k  = 0;
        np = 0;
        while (k < 40 && !done) begin
            @(posedge clk);
            k++;
            #1;
            if (k == 1) target = ~t; // must be ignored after SETUP
            // probe j's address is stable right after edge 1 + 2*j
            if (!done && ((k - 1) % 2) == 0) begin
                if (np < 6) got[np] = rom_addr;
                np++;
            end
        end
        check({tag, "_done_edge"}, k, exp_edge);
        check({tag, "_found"}, found, exp_f);
        check({tag, "_loc"}, loc, exp_loc);
        check({tag, "_probes"}, np, exp_p);
`ifdef BS_CTRL_PROBE_CNT_EN
        check({tag, "_probe_cnt"}, probes, exp_p);
`endif
        for (int j = 0; j < exp_p && j < np && j < 6; j++)
            check({tag, "_addr"}, got[j], exp_addr[j]);
    endtask

    task automatic release_start(input logic exp_f, input logic [4:0] exp_loc);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rel_done", done, 1'b0);
        check("rel_busy", busy, 1'b0);
        check("rel_found_held", found, exp_f);
        check("rel_loc_held", loc, exp_loc);
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        target = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_found", found, 1'b0);
        check("rst_loc", loc, 5'd0);
        check("rst_addr", rom_addr, 5'd0);
        @(negedge clk);
        reset = 1'b1;

        // start low in IDLE: nothing moves
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);

        // hit at first probe
        exp_addr = '{15, 0, 0, 0, 0, 0};
        do_search("hit31", 8'd31, 1'b1, 5'd15, 3, 1);
        release_start(1'b1, 5'd15);

        // worst-case hit
        exp_addr = '{15, 23, 27, 29, 30, 31};
        do_search("hit63", 8'd63, 1'b1, 5'd31, 13, 6);
        release_start(1'b1, 5'd31);

        // low miss, exits on mid==0
        exp_addr = '{15, 7, 3, 1, 0, 0};
        do_search("miss0", 8'd0, 1'b0, 5'd0, 11, 5);
        release_start(1'b0, 5'd0);

        // high miss, exits on mid==max
        exp_addr = '{15, 23, 27, 29, 30, 31};
        do_search("miss64", 8'd64, 1'b0, 5'd0, 13, 6);
        release_start(1'b0, 5'd0);

        // gap miss, exits on lo>hi
        exp_addr = '{15, 23, 19, 17, 16, 0};
        do_search("miss32", 8'd32, 1'b0, 5'd0, 11, 5);

        // start held high: stays in DONE
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", done, 1'b1);
        check("hold_busy", busy, 1'b0);
        release_start(1'b0, 5'd0);

        // hit, then result held through IDLE
        exp_addr = '{15, 0, 0, 0, 0, 0};
        do_search("hit31b", 8'd31, 1'b1, 5'd15, 3, 1);
        release_start(1'b1, 5'd15);
        repeat (2) @(posedge clk);
        #1;
        check("idle_found_held", found, 1'b1);
        check("idle_loc_held", loc, 5'd15);

        // lowest entry
        exp_addr = '{15, 7, 3, 1, 0, 0};
        do_search("hit1", 8'd1, 1'b1, 5'd0, 11, 5);
        release_start(1'b1, 5'd0);

        // reset during third SEARCH cycle (after edge 5)
        target = 8'd63;
        start  = 1'b1;
        @(posedge clk);              // edge 0
        repeat (5) @(posedge clk);   // edges 1..5
        #1;
        check("pre_rst_busy", busy, 1'b1);
        #1;
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_found", found, 1'b0);
        check("arst_loc", loc, 5'd0);
        check("arst_addr", rom_addr, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", busy, 1'b0);

        exp_addr = '{15, 23, 19, 17, 16, 0};
        do_search("hit33", 8'd33, 1'b1, 5'd16, 11, 5);
        release_start(1'b1, 5'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bs_ctrl
`default_nettype wire
